// File: rtl/alu_seq.sv
// alu_seq: registered ALU with C/Z/N/V flags, chained carry and iterative one-bit-per-clock shifts/rotates.
// Single-cycle ops commit at the accept edge; shift ops run under a two-state FSM.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       s,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin_ext,
    input  logic             use_ext_c,
    output logic [WIDTH-1:0] f,
    output logic             c_flag,
    output logic             z_flag,
    output logic             n_flag,
    output logic             v_flag,
    output logic             busy,
    output logic             done
);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t           state, state_n;
    logic [WIDTH-1:0] work, work_n, f_n, op2, res, step_f;
    logic [SW-1:0]    cnt, cnt_n;
    logic [3:0]       op, op_n;
    logic             c_work, cw_n, c_n, z_n, n_n, v_n, busy_n, done_n;
    logic             ci, cin, step_c, is_shift, upd_c, upd_v;
    logic [WIDTH:0]   sum;
    assign ci       = use_ext_c ? cin_ext : c_flag;
    assign is_shift = s >= 4'd12 && s <= 4'd14;
    assign upd_c    = (s >= 4'd1 && s <= 4'd6) || s == 4'd15;
    assign upd_v    = (s >= 4'd2 && s <= 4'd5) || s == 4'd15;
    assign op2      = (s == 4'd2 || s == 4'd3) ? b :
                      (s == 4'd4 || s == 4'd5 || s == 4'd15) ? ~b :
                      (s == 4'd6) ? '1 : '0;
    assign cin      = (s == 4'd1 || s == 4'd5 || s == 4'd15) ? 1'b1 : (s == 4'd3) ? ci : 1'b0;
    assign sum      = {1'b0, a} + {1'b0, op2} + {{WIDTH{1'b0}}, cin};
    always_comb begin
        res = sum[WIDTH-1:0];
        case (s)
            4'd0:    res = a;
            4'd7:    res = b;
            4'd8:    res = a & b;
            4'd9:    res = a | b;
            4'd10:   res = a ^ b;
            4'd11:   res = ~a;
            default: res = sum[WIDTH-1:0];
        endcase
    end
    // Op 12 feeds a zero into the MSB; 13/14 rotate through the working carry.
    assign step_f = op == 4'd14 ? {work[WIDTH-2:0], c_work} : {op == 4'd13 ? c_work : 1'b0, work[WIDTH-1:1]};
    assign step_c = op == 4'd14 ? work[WIDTH-1] : work[0];
    always_comb begin
        state_n = state;
        f_n     = f;
        c_n     = c_flag;
        z_n     = z_flag;
        n_n     = n_flag;
        v_n     = v_flag;
        busy_n  = busy;
        done_n  = 1'b0;
        work_n  = work;
        cw_n    = c_work;
        cnt_n   = cnt;
        op_n    = op;
        case (state)
            IDLE: if (start) begin
                if (is_shift) begin
                    work_n  = a;
                    cw_n    = s == 4'd12 ? c_flag : ci;
                    cnt_n   = b[SW-1:0];
                    op_n    = s;
                    busy_n  = 1'b1;
                    state_n = SHIFT;
                end else begin
                    f_n    = s == 4'd15 ? f : res;
                    z_n    = res == '0;
                    n_n    = res[WIDTH-1];
                    c_n    = upd_c ? sum[WIDTH] : c_flag;
                    v_n    = upd_v ? (a[WIDTH-1] == op2[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]) : v_flag;
                    done_n = 1'b1;
                end
            end
            SHIFT: if (cnt != '0) begin
                work_n = step_f;
                cw_n   = step_c;
                cnt_n  = cnt - 1'b1;
            end else begin
                f_n     = work;
                c_n     = c_work;
                z_n     = work == '0;
                n_n     = work[WIDTH-1];
                busy_n  = 1'b0;
                done_n  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            f      <= '0;
            c_flag <= 1'b0;
            z_flag <= 1'b0;
            n_flag <= 1'b0;
            v_flag <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            work   <= '0;
            c_work <= 1'b0;
            cnt    <= '0;
            op     <= '0;
        end else begin
            state  <= state_n;
            f      <= f_n;
            c_flag <= c_n;
            z_flag <= z_n;
            n_flag <= n_n;
            v_flag <= v_n;
            busy   <= busy_n;
            done   <= done_n;
            work   <= work_n;
            c_work <= cw_n;
            cnt    <= cnt_n;
            op     <= op_n;
        end
    end
endmodule
